// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - instruction issue controller for the 16-bit combinational ALU
module alu_issue_ctrl #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Counter preload: the ALU inputs are held SETTLE edges before alu_z is taken.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t           state;
    logic [WIDTH-1:0] rf [4];
    logic [3:0]       cnt;
    logic [1:0]       rd_q;

    logic [2:0]       op;
    logic [1:0]       rd;
    logic [1:0]       ra;
    logic [1:0]       rb;
    logic [7:0]       imm;
    logic [WIDTH-1:0] imm_ext;

    assign op      = instr[15:13];
    assign rd      = instr[12:11];
    assign ra      = instr[10:9];
    assign rb      = instr[8:7];
    assign imm     = instr[7:0];
    assign imm_ext = {{(WIDTH-8){1'b0}}, imm};

    // Only IDLE takes instructions; a response must drain before the next accept.
    assign in_ready = (state == IDLE);

    // Issue FSM, register file and registered ALU/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= 2'b00;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            cnt       <= '0;
            rd_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!op[2]) begin
                            // ALU op: operands captured now, so RD==RA/RB uses old values.
                            alu_a   <= rf[ra];
                            alu_b   <= rf[rb];
                            alu_fun <= op[1:0];
                            cnt     <= CNT_INIT;
                            rd_q    <= rd;
                            state   <= ISSUE;
                        end else begin
                            res_valid <= 1'b1;
                            state     <= RESP;
                            if (op[1]) begin
                                res_data <= '0;
                                res_err  <= 1'b1;
                            end else if (op[0]) begin
                                res_data <= rf[ra];
                                res_err  <= 1'b0;
                            end else begin
                                rf[rd]   <= imm_ext;
                                res_data <= imm_ext;
                                res_err  <= 1'b0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rf[rd_q]  <= alu_z;
                        res_data  <= alu_z;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with SETTLE=1 and SETTLE=4 instances
module tb_alu_issue_ctrl;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] instr     [2];
    logic [15:0] alu_a     [2];
    logic [15:0] alu_b     [2];
    logic [1:0]  alu_fun   [2];
    logic [15:0] alu_z     [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [15:0] res_data  [2];
    logic        res_err   [2];

    logic [15:0] mdl [2][4];
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] g;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
        case (f)
            2'b00:   return a + b;
            2'b01:   return a & b;
            2'b10:   return ~a;
            default: return a >> 1;
        endcase
    endfunction

    // External combinational ALU for each instance
    assign alu_z[0] = alu_f(alu_a[0], alu_b[0], alu_fun[0]);
    assign alu_z[1] = alu_f(alu_a[1], alu_b[1], alu_fun[1]);

    alu_issue_ctrl #(.WIDTH(16), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .instr(instr[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_fun(alu_fun[0]), .alu_z(alu_z[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]), .res_err(res_err[0])
    );

    alu_issue_ctrl #(.WIDTH(16), .SETTLE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .instr(instr[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_fun(alu_fun[1]), .alu_z(alu_z[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]), .res_err(res_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_i(input logic [1:0] fun, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
        return {1'b0, fun, rd, ra, rb, 7'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {3'b100, rd, 3'b000, imm};
    endfunction

    function automatic logic [15:0] out_i(input logic [1:0] ra);
        return {3'b101, 2'b00, ra, 9'b0};
    endfunction

    function automatic void clear_model();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 4; r++)
                mdl[d][r] = 16'h0000;
    endfunction

    // Drive one instruction, scoreboard its result, optionally backpressure and poke in_valid during RESP
    task automatic issue(input int d, input logic [15:0] ins, input int hold, input bit poke, output logic [15:0] got);
        exp_t        e;
        exp_t        p;
        logic [2:0]  op;
        logic [1:0]  rd, ra, rb;
        logic [15:0] a_exp, b_exp;
        int          lat;
        int          exp_lat;
        op = ins[15:13];
        rd = ins[12:11];
        ra = ins[10:9];
        rb = ins[8:7];
        a_exp = mdl[d][ra];
        b_exp = mdl[d][rb];
        if (!op[2]) begin
            e.data = alu_f(a_exp, b_exp, op[1:0]);
            e.err  = 1'b0;
            mdl[d][rd] = e.data;
        end else if (op[1]) begin
            e.data = 16'h0000;
            e.err  = 1'b1;
        end else if (op[0]) begin
            e.data = a_exp;
            e.err  = 1'b0;
        end else begin
            e.data = {8'h00, ins[7:0]};
            e.err  = 1'b0;
            mdl[d][rd] = e.data;
        end
        exp_lat = op[2] ? 1 : ((d == 1) ? 5 : 2);

        @(negedge clk);
        instr[d]    = ins;
        in_valid[d] = 1'b1;
        check("in_ready_idle", 32'(in_ready[d]), 32'd1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        instr[d]    = 16'hDEAD;
        lat = 1;
        if (!op[2]) begin
            check("issue_alu_a", 32'(alu_a[d]), 32'(a_exp));
            check("issue_alu_b", 32'(alu_b[d]), 32'(b_exp));
            check("issue_alu_fun", 32'(alu_fun[d]), 32'(op[1:0]));
        end
        while (!res_valid[d] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (!res_valid[d])
                check("issue_fun_hold", 32'(alu_fun[d]), 32'(op[1:0]));
        end
        check("latency", 32'(lat), 32'(exp_lat));
        got = res_data[d];

        if (poke) begin
            in_valid[d] = 1'b1;
            instr[d]    = ldi(2'd0, 8'hAA);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(res_valid[d]), 32'd1);
            check("hold_data", 32'(res_data[d]), 32'(got));
            check("hold_in_ready", 32'(in_ready[d]), 32'd0);
        end

        if (sb.size() > 0) begin
            p = sb.pop_front();
            check("res_data", 32'(res_data[d]), 32'(p.data));
            check("res_err", 32'(res_err[d]), 32'(p.err));
        end else begin
            check("sb_underflow", 32'd1, 32'd0);
        end

        res_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        res_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        check("drain_valid", 32'(res_valid[d]), 32'd0);
        check("drain_in_ready", 32'(in_ready[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            res_ready[d] = 1'b0;
            instr[d]     = 16'h0000;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 32'(in_ready[d]), 32'd1);
            check("rst_res_valid", 32'(res_valid[d]), 32'd0);
            check("rst_res_data", 32'(res_data[d]), 32'd0);
            check("rst_res_err", 32'(res_err[d]), 32'd0);
            check("rst_alu_a", 32'(alu_a[d]), 32'd0);
            check("rst_alu_fun", 32'(alu_fun[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ALU functions on the SETTLE=1 instance
        issue(0, ldi(2'd0, 8'h34), 0, 1'b0, g);
        check("ldi_r0", 32'(g), 32'h0034);
        issue(0, ldi(2'd1, 8'h0F), 0, 1'b0, g);
        issue(0, alu_i(2'b00, 2'd2, 2'd0, 2'd1), 0, 1'b0, g);
        check("add_r2", 32'(g), 32'h0043);
        issue(0, alu_i(2'b01, 2'd3, 2'd0, 2'd1), 0, 1'b0, g);
        check("and_r3", 32'(g), 32'h0004);
        issue(0, out_i(2'd3), 0, 1'b0, g);
        issue(0, alu_i(2'b10, 2'd3, 2'd0, 2'd0), 0, 1'b0, g);
        check("not_r3", 32'(g), 32'hFFCB);
        issue(0, out_i(2'd3), 0, 1'b0, g);
        issue(0, alu_i(2'b11, 2'd3, 2'd0, 2'd0), 0, 1'b0, g);
        check("shr_r3", 32'(g), 32'h001A);
        issue(0, out_i(2'd3), 0, 1'b0, g);

        // Wrap-around, with backpressure and ignored in_valid during RESP
        issue(0, ldi(2'd0, 8'h00), 0, 1'b0, g);
        issue(0, alu_i(2'b10, 2'd0, 2'd0, 2'd0), 0, 1'b0, g);
        check("not_r0", 32'(g), 32'hFFFF);
        issue(0, ldi(2'd1, 8'h01), 0, 1'b0, g);
        issue(0, alu_i(2'b00, 2'd0, 2'd0, 2'd1), 5, 1'b1, g);
        check("add_wrap", 32'(g), 32'h0000);
        issue(0, out_i(2'd0), 0, 1'b0, g);

        // Illegal opcode, then confirm no register changed
        issue(0, {3'b111, 13'h1A5A}, 2, 1'b0, g);
        for (int r = 0; r < 4; r++)
            issue(0, out_i(2'(r)), 0, 1'b0, g);

        // SETTLE=4 instance: latency 5 edges, backpressure
        issue(1, ldi(2'd0, 8'h34), 0, 1'b0, g);
        issue(1, ldi(2'd1, 8'h0F), 0, 1'b0, g);
        issue(1, alu_i(2'b00, 2'd2, 2'd0, 2'd1), 5, 1'b1, g);
        check("add_settle4", 32'(g), 32'h0043);
        issue(1, out_i(2'd0), 0, 1'b0, g);

        // Reset in the middle of ISSUE
        issue(0, ldi(2'd0, 8'h34), 0, 1'b0, g);
        issue(0, ldi(2'd1, 8'h0F), 0, 1'b0, g);
        @(negedge clk);
        instr[0]    = alu_i(2'b00, 2'd2, 2'd0, 2'd1);
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("mid_issue_in_ready", 32'(in_ready[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(res_valid[0]), 32'd0);
        check("async_rst_data", 32'(res_data[0]), 32'd0);
        check("async_rst_err", 32'(res_err[0]), 32'd0);
        check("async_rst_alu_a", 32'(alu_a[0]), 32'd0);
        check("async_rst_alu_b", 32'(alu_b[0]), 32'd0);
        check("async_rst_alu_fun", 32'(alu_fun[0]), 32'd0);
        check("async_rst_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        issue(0, out_i(2'd2), 0, 1'b0, g);
        check("r2_after_rst", 32'(g), 32'h0000);
        issue(1, out_i(2'd2), 0, 1'b0, g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
